// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial bit-pattern detector. Shifts accepted
//                bits of w into a history register and pulses z for one
//                cycle whenever the last N accepted bits equal the active
//                pattern. Supports overlapping / non-overlapping detection,
//                a sample-enable qualifier, runtime pattern reload and a
//                saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             COUNT_W = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               w,
  input  logic               Ovl,
  input  logic               LoadPat,
  input  logic [N-1:0]       PatIn,
  output logic               z,
  output logic [COUNT_W-1:0] Count
);

  // Fill counter only needs to reach N, so it is sized for 0..N.
  localparam int                FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  // Registered state
  logic [N-1:0]       pat_q;
  logic [N-1:0]       hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic               z_q;
  logic [COUNT_W-1:0] count_q;

  // Next-state values
  logic [N-1:0]       pat_d;
  logic [N-1:0]       hist_d;
  logic [FILL_W-1:0]  fill_d;
  logic               z_d;
  logic [COUNT_W-1:0] count_d;

  // Datapath helpers for an accepted sample
  logic [N-1:0]       hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;
  logic               count_full;

  // Shifted history, saturating fill and the match decision for this edge.
  always_comb begin
    hist_shift = {hist_q[N-2:0], w};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
    // Compare only against the committed pattern, never against PatIn.
    match      = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
    count_full = &count_q;
  end

  // Next-state selection: LoadPat outranks a sample, a sample outranks idle.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    z_d     = 1'b0;
    count_d = count_q;

    if (LoadPat) begin
      // New pattern: discard partial history and restart the count.
      pat_d   = PatIn;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (En) begin
      hist_d = hist_shift;
      if (match) begin
        z_d = 1'b1;
        if (!count_full) begin
          count_d = count_q + COUNT_W'(1);
        end
        // Overlap keeps the shared suffix valid; otherwise need N fresh bits.
        fill_d = Ovl ? FILL_FULL : '0;
      end else begin
        fill_d = fill_inc;
      end
    end
    // Idle: everything holds except z, which drops so a pulse never stretches.
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      z_q     <= 1'b0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  assign z     = z_q;
  assign Count = count_q;

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector. It samples a one-bit stream `w` and pulses `z` each time the last N accepted bits equal a programmable pattern. It supports overlapping and non-overlapping detection, a sample-enable qualifier, runtime pattern reload and a saturating match counter. It is the general successor to the fixed-pattern, fixed-length Moore detectors in this design and sits directly on serial control/data lines.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: reset pattern, N bits wide; bit N-1 is the first bit received.
- `COUNT_W`, 8: width of the match counter.
- `Clk` input 1: the single clock; all state updates on its rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `En` input 1: sample qualifier; `w` is accepted only on edges where `En`=1.
- `w` input 1: serial data bit.
- `Ovl` input 1: 1 = overlapping detection, 0 = non-overlapping; sampled on every accepted edge.
- `LoadPat` input 1: load `PatIn` as the active pattern.
- `PatIn` input N: new pattern, first-received bit in the MSB.
- `z` output 1: registered match pulse.
- `Count` output COUNT_W: number of matches, saturating.

## Operation
- State:
  - `pat[N-1:0]` holds the active pattern.
  - `hist[N-1:0]` holds the bit history: `hist_next = {hist[N-2:0], w}`.
  - `fill`, width clog2(N+1), counts valid history bits and saturates at N.
- Priority per edge: `Rst` > `LoadPat` > `En` > idle.
- Reset:
  - `pat` ← `PATTERN`; `hist`, `fill`, `z` and `Count` ← 0.
- LoadPat:
  - `pat` ← `PatIn`; `hist`, `fill`, `z` and `Count` ← 0.
  - `w` is ignored on that edge even when `En`=1.
- Accepted sample (`En`=1, no Rst or LoadPat):
  - `hist` ← `hist_next`; `fill_next` = min(`fill`+1, N).
  - A match occurs when `fill_next`==N and `hist_next`==`pat`.
  - On a match, `z` ← 1 and `Count` ← `Count`+1, holding at 2^COUNT_W−1 once saturated.
  - With no match, `z` ← 0.
  - Match with `Ovl`=1: `fill` ← N. The shared suffix bits count toward the next match.
  - Match with `Ovl`=0: `fill` ← 0. The next match needs N fresh accepted bits.
- Idle (`En`=0):
  - `hist`, `fill`, `pat` and `Count` hold.
  - `z` ← 0, so a pulse never stretches across idle cycles.
- Matching is combinational against `pat` only. `w` must never be compared against `PatIn` except through a completed load.

## Timing
- Latency: `z` is high for exactly the one cycle following the edge that accepted the final pattern bit. `Count` updates on the same edge.
- Back-to-back matches with `Ovl`=1 (for example an all-ones pattern) give `z` high on consecutive cycles. `Count` increments on each of them.
- `Ovl` may change at any accepted edge. It only affects that edge's `fill` update.
- Reset mid-pattern discards any partial match. The first possible `z` comes N accepted bits after `Rst` falls.
- `LoadPat` mid-stream behaves the same way: partial history is discarded and `Count` is cleared.
- Outputs are glitch-free registers. There is no combinational path from inputs to `z` or `Count`.
- Reset values: `z`=0 and `Count`=0. `pat`=`PATTERN` is not visible at a port.

## Test plan
1. **Reset values.** Assert `Rst` for 2 cycles with `w` toggling → `z`=0 and `Count`=0 throughout. The default pattern 1011 then matches after 4 accepted bits.
2. **Overlapping stream.** `Ovl`=1, `En`=1, stream 1,0,1,1,0,1,1 → `z` pulses one cycle after the 4th and after the 7th bit. Final `Count`=2.
3. **Non-overlapping stream.** `Ovl`=0, same stream as scenario 2 → `z` pulses only after the 4th bit. Final `Count`=1. Separately, pattern 1111 with six 1s gives `Count`=1 for `Ovl`=0 and `Count`=3 for `Ovl`=1.
4. **Enable gaps.** Send 1, then `En`=0 for 3 cycles while `w`=0, then 0,1,1 → exactly one `z` pulse, after the last bit. `z`=0 during the gap cycles.
5. **Pattern reload.** After 1,0,1, pulse `LoadPat` with `PatIn`=0110 and `w`=1 on the same edge → `Count`=0. Then feed 1, then 0,1,1,0 → no `z` on the trailing 1 of the old prefix. One `z` pulse after the final 0, and `Count`=1.
6. **Reset mid-pattern and saturation.**
   - Feed 1,0,1, assert `Rst`, then feed 1 → no `z`.
   - With `COUNT_W`=2, feed 5 matches → `Count` reads 1, 2, 3, 3, 3, and `z` still pulses on every match.
